jk_excitation_driver: RTL and testbench

- Drives the J/K inputs of an external bank of WIDTH JK flip-flops (posedge CLK, active-low Preset/Clear) to move the bank from its current state to a requested target state.
- Excitation is computed from the JK excitation table using the bank's Q outputs fed back.
- After driving, the block checks the feedback, retries on mismatch, and reports done or error.
- It sits between control logic and any register built from JK flip-flops.

---
 rtl/jk_excitation_driver_if.sv | 24 ++
 rtl/jk_excitation_driver.sv | 145 ++++++++++++++
 tb/tb_jk_excitation_driver.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// Handshake and bank-facing bus between the control logic and the JK excitation driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] Q_fb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] mismatch;

  modport master (
    output start, target, Q_fb,
    input  J, K, busy, done, error, mismatch
  );

  modport slave (
    input  start, target, Q_fb,
    output J, K, busy, done, error, mismatch
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flip-flop bank toward a target, verifies the feedback, retries, reports.
// Build option: JK_TOGGLE_EN encodes changing bits as toggle (J=K=1) instead of set/reset.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_DRIVE | J/K presented to the bank for one edge
//   S_CHECK | compare Q_fb with target_q, retry or finish
//   S_DONE  | one-cycle done pulse
//   S_ERROR | retries exhausted, error held until next start
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                  CLK,
  input  logic                  Clear,
  jk_excitation_driver_if.slave bus
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] mismatch_q, mismatch_d;
  logic [WIDTH-1:0] diff;
  logic             can_retry;

  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
    return q ^ t;
`else
    return ~q & t;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
    return q ^ t;
`else
    return q & ~t;
`endif
  endfunction

  assign diff      = bus.Q_fb ^ target_q;
  assign can_retry = (retry_q < MAX_R);

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      retry_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mismatch_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      retry_q    <= retry_d;
      j_q        <= j_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERROR: if (bus.start) state_d = S_DRIVE;
      S_DRIVE:         state_d = S_CHECK;
      S_CHECK: begin
        if (diff == '0)     state_d = S_DONE;
        else if (can_retry) state_d = S_DRIVE;
        else                state_d = S_ERROR;
      end
      S_DONE:          state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // J/K default to zero so they are only ever non-zero while in S_DRIVE.
  always_comb begin
    target_d   = target_q;
    retry_d    = retry_q;
    j_d        = '0;
    k_d        = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    mismatch_d = mismatch_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          target_d = bus.target;
          retry_d  = '0;
          j_d      = exc_j(bus.Q_fb, bus.target);
          k_d      = exc_k(bus.Q_fb, bus.target);
          busy_d   = 1'b1;
          error_d  = 1'b0;
        end
      end
      S_CHECK: begin
        mismatch_d = diff;
        if (diff == '0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (can_retry) begin
          retry_d = retry_q + RW'(1);
          j_d     = exc_j(bus.Q_fb, target_q);
          k_d     = exc_k(bus.Q_fb, target_q);
        end else begin
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.J        = j_q;
  assign bus.K        = k_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: behavioural JK bank with stuck-at-0 bits, vector table plus scoreboard.
module tb_jk_excitation_driver;
  localparam int W = 4;
`ifdef JK_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  jk_excitation_driver_if #(.WIDTH(W)) bus_if();

  jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
    .CLK  (clk),
    .Clear(clear),
    .bus  (bus_if)
  );

  logic [W-1:0] bank, load_val, stuck0;
  logic         load_en;
  assign bus_if.Q_fb = bank;

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j, input logic [W-1:0] k);
    logic [W-1:0] n;
    for (int b = 0; b < W; b++) begin
      case ({j[b], k[b]})
        2'b00:   n[b] = q[b];
        2'b01:   n[b] = 1'b0;
        2'b10:   n[b] = 1'b1;
        default: n[b] = ~q[b];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (load_en) bank <= load_val & ~stuck0;
    else         bank <= jk_next(bank, bus_if.J, bus_if.K) & ~stuck0;
  end

  typedef struct {
    logic [W-1:0] q0, tgt, stuck, exp_j, exp_k;
    int           exp_drives;
    bit           exp_err;
    logic [W-1:0] exp_mism, exp_bank;
  } vec_t;

  typedef struct {
    int           cycle;
    bit           err;
    logic [W-1:0] mism, bank;
  } exp_t;

  vec_t vt[5];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v, input logic [W-1:0] stk);
    stuck0   = stk;
    load_val = v;
    load_en  = 1'b1;
    @(posedge clk); #1;
    load_en  = 1'b0;
  endtask

  task automatic check_outcome(input string tag, input int c, input bit got);
    exp_t e;
    chk({tag, "_seen"}, 32'(got), 32'd1);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      if (got) begin
        chk({tag, "_latency"}, 32'(c), 32'(e.cycle));
        chk({tag, "_error"}, 32'(bus_if.error), 32'(e.err));
        chk({tag, "_done"}, 32'(bus_if.done), 32'(!e.err));
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, "_mismatch"}, 32'(bus_if.mismatch), 32'(e.mism));
        chk({tag, "_bank"}, 32'(bank), 32'(e.bank));
      end
    end
  endtask

  initial begin
    int           c, drives, dones;
    bit           got, quiet;
    string        tag;

    clear = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.target = '0;
    load_en  = 1'b0;
    load_val = '0;
    stuck0   = '0;

    vt[0] = '{q0:4'b0000, tgt:4'b1010, stuck:4'b0000, exp_j:4'b1010, exp_k:(TOG ? 4'b1010 : 4'b0000),
              exp_drives:1, exp_err:1'b0, exp_mism:4'b0000, exp_bank:4'b1010};
    vt[1] = '{q0:4'b1111, tgt:4'b0110, stuck:4'b0000, exp_j:(TOG ? 4'b1001 : 4'b0000), exp_k:4'b1001,
              exp_drives:1, exp_err:1'b0, exp_mism:4'b0000, exp_bank:4'b0110};
    vt[2] = '{q0:4'b1100, tgt:4'b0101, stuck:4'b0000, exp_j:(TOG ? 4'b1001 : 4'b0001),
              exp_k:(TOG ? 4'b1001 : 4'b1000),
              exp_drives:1, exp_err:1'b0, exp_mism:4'b0000, exp_bank:4'b0101};
    vt[3] = '{q0:4'b0011, tgt:4'b0011, stuck:4'b0000, exp_j:4'b0000, exp_k:4'b0000,
              exp_drives:0, exp_err:1'b0, exp_mism:4'b0000, exp_bank:4'b0011};
    vt[4] = '{q0:4'b0000, tgt:4'b0001, stuck:4'b0001, exp_j:4'b0001, exp_k:(TOG ? 4'b0001 : 4'b0000),
              exp_drives:4, exp_err:1'b1, exp_mism:4'b0001, exp_bank:4'b0000};

    // reset state
    #12;
    chk("rst_J", 32'(bus_if.J), 32'd0);
    chk("rst_K", 32'(bus_if.K), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_error", 32'(bus_if.error), 32'd0);
    chk("rst_mismatch", 32'(bus_if.mismatch), 32'd0);
    clear = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("v%0d", i);
      load_bank(vt[i].q0, vt[i].stuck);
      sbq.push_back('{cycle:(vt[i].exp_err ? 9 : 3), err:vt[i].exp_err,
                      mism:vt[i].exp_mism, bank:vt[i].exp_bank});
      bus_if.start  = 1'b1;
      bus_if.target = vt[i].tgt;
      @(posedge clk); #1;
      bus_if.start  = 1'b0;
      bus_if.target = ~vt[i].tgt;
      @(negedge clk);
      c = 1;
      chk({tag, "_drive1_J"}, 32'(bus_if.J), 32'(vt[i].exp_j));
      chk({tag, "_drive1_K"}, 32'(bus_if.K), 32'(vt[i].exp_k));
      chk({tag, "_drive1_busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, "_drive1_error"}, 32'(bus_if.error), 32'd0);
      drives = 0;
      got = 1'b0;
      while (!got && c <= 30) begin
        if ((bus_if.J | bus_if.K) != '0) begin
          drives++;
          if (c > 1) chk({tag, "_retry_J"}, 32'(bus_if.J), 32'(vt[i].exp_j));
        end
        if (bus_if.done || bus_if.error) got = 1'b1;
        else begin
          @(negedge clk);
          c++;
        end
      end
      check_outcome(tag, c, got);
      chk({tag, "_drives"}, 32'(drives), 32'(vt[i].exp_drives));
      if (vt[i].exp_err) begin
        repeat (3) @(negedge clk);
        chk({tag, "_error_held"}, 32'(bus_if.error), 32'd1);
        chk({tag, "_err_jk_zero"}, 32'(bus_if.J | bus_if.K), 32'd0);
      end else begin
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 32'(bus_if.done), 32'd0);
      end
    end

    // async Clear while sitting in ERROR
    #2 clear = 1'b0;
    #1 chk("clr_err_error", 32'(bus_if.error), 32'd0);
    clear = 1'b1;

    // async Clear in the middle of a DRIVE cycle
    load_bank(4'b0000, 4'b0000);
    bus_if.start  = 1'b1;
    bus_if.target = 4'b1010;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    #2;
    chk("clr_drive_J_before", 32'(bus_if.J), 32'(4'b1010));
    clear = 1'b0;
    #1;
    chk("clr_drive_J", 32'(bus_if.J), 32'd0);
    chk("clr_drive_K", 32'(bus_if.K), 32'd0);
    chk("clr_drive_busy", 32'(bus_if.busy), 32'd0);
    chk("clr_drive_error", 32'(bus_if.error), 32'd0);
    clear = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy || (bus_if.J | bus_if.K) != '0) quiet = 1'b0;
    end
    chk("clr_drive_idle_quiet", 32'(quiet), 32'd1);

    // start re-asserted during CHECK must be ignored
    load_bank(4'b0000, 4'b0000);
    sbq.push_back('{cycle:3, err:1'b0, mism:4'b0000, bank:4'b1010});
    bus_if.start  = 1'b1;
    bus_if.target = 4'b1010;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    bus_if.start  = 1'b1;
    bus_if.target = 4'b0011;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(negedge clk);
    c = 3;
    got = bus_if.done;
    check_outcome("restart", c, got);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    chk("restart_extra_dones", 32'(dones), 32'd0);
    chk("restart_bank_final", 32'(bank), 32'(4'b1010));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
